// File: rtl/ip_update_pkg.sv
// Shared types and opcode-to-ip mapping functions for the ip update arbiter.
package ip_update_pkg;

   typedef logic [1:0] op_t;
   typedef logic [1:0] ip_t;
   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

   function automatic ip_t map_a(input op_t op);
      return op + 2'd1;
   endfunction

   function automatic ip_t map_b(input op_t op);
      return 2'd3 - op;
   endfunction

endpackage

// File: rtl/ip_req_fifo.sv
// Per-source request FIFO; flush empties it and discards any same-cycle push.
module ip_req_fifo
   import ip_update_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  op_t  data_in,
   output op_t  data_out,
   output logic empty,
   output logic full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne = AW'(1);
   localparam logic [AW:0] CntOne = (AW + 1)'(1);
   localparam logic [AW:0] CntDepth = (AW + 1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] cnt_q, cnt_d;
   op_t mem_q [DEPTH];
   logic do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full = (cnt_q == CntDepth);
   assign do_push = push && !full && !flush;
   assign do_pop = pop && !empty && !flush;
   assign data_out = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
         if (do_pop) rd_ptr_d = rd_ptr_q + PtrOne;
         if (do_push && !do_pop) cnt_d = cnt_q + CntOne;
         else if (!do_push && do_pop) cnt_d = cnt_q - CntOne;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= data_in;
   end

endmodule

// File: rtl/ip_update_arbiter.sv
// Queues ip-update requests from sources A and B and grants at most one per cycle,
// round-robin on contention, with a saturating conflict counter.
module ip_update_arbiter
   import ip_update_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 a_valid,
   input  logic [1:0]           a_in,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [1:0]           b_in,
   output logic                 b_ready,
   input  logic                 stall,
   input  logic                 flush,
   output logic [1:0]           ip,
   output logic                 ip_valid,
   output logic                 ip_src,
   output logic [CNT_WIDTH-1:0] conflicts
);

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   op_t a_data, b_data;
   logic a_empty, a_full, b_empty, b_full;
   logic pop_a, pop_b, conflict;

   ip_t ip_q, ip_d;
   logic ip_valid_q, ip_valid_d;
   src_t ip_src_q, ip_src_d;
   src_t rr_q, rr_d;
   logic [CNT_WIDTH-1:0] conflicts_q, conflicts_d;

   assign a_ready = !a_full;
   assign b_ready = !b_full;

   ip_req_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clock   (clock),
      .reset   (reset),
      .push    (a_valid && a_ready),
      .pop     (pop_a),
      .flush   (flush),
      .data_in (a_in),
      .data_out(a_data),
      .empty   (a_empty),
      .full    (a_full)
   );

   ip_req_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clock   (clock),
      .reset   (reset),
      .push    (b_valid && b_ready),
      .pop     (pop_b),
      .flush   (flush),
      .data_in (b_in),
      .data_out(b_data),
      .empty   (b_empty),
      .full    (b_full)
   );

   always_comb begin
      pop_a = 1'b0;
      pop_b = 1'b0;
      conflict = 1'b0;
      if (!stall && !flush) begin
         if (!a_empty && !b_empty) begin
            conflict = 1'b1;
            if (rr_q == SRC_A) pop_a = 1'b1;
            else pop_b = 1'b1;
         end else if (!a_empty) begin
            pop_a = 1'b1;
         end else if (!b_empty) begin
            pop_b = 1'b1;
         end
      end
   end

   always_comb begin
      ip_d = ip_q;
      ip_src_d = ip_src_q;
      ip_valid_d = 1'b0;
      rr_d = rr_q;
      conflicts_d = conflicts_q;
      if (pop_a) begin
         ip_d = map_a(a_data);
         ip_src_d = SRC_A;
         ip_valid_d = 1'b1;
      end else if (pop_b) begin
         ip_d = map_b(b_data);
         ip_src_d = SRC_B;
         ip_valid_d = 1'b1;
      end
      // The pointer only moves when both sources actually contended.
      if (conflict) begin
         rr_d = (rr_q == SRC_A) ? SRC_B : SRC_A;
         if (conflicts_q != CntMax) conflicts_d = conflicts_q + CntOne;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ip_q <= '0;
         ip_valid_q <= 1'b0;
         ip_src_q <= SRC_A;
         rr_q <= SRC_A;
         conflicts_q <= '0;
      end else begin
         ip_q <= ip_d;
         ip_valid_q <= ip_valid_d;
         ip_src_q <= ip_src_d;
         rr_q <= rr_d;
         conflicts_q <= conflicts_d;
      end
   end

   assign ip = ip_q;
   assign ip_valid = ip_valid_q;
   assign ip_src = ip_src_q;
   assign conflicts = conflicts_q;

endmodule

// File: tb/tb_ip_update_arbiter.sv
// Directed self-checking bench for ip_update_arbiter.
module tb_ip_update_arbiter;

   logic clock = 1'b0;
   logic reset;
   logic a_valid, b_valid, stall, flush;
   logic [1:0] a_in, b_in;
   logic a_ready, b_ready, ip_valid, ip_src;
   logic [1:0] ip;
   logic [7:0] conflicts;

   // Second instance with a 2-bit counter for the saturation scenario.
   logic s_a_valid, s_b_valid, s_stall, s_flush;
   logic [1:0] s_a_in, s_b_in;
   logic s_a_ready, s_b_ready, s_ip_valid, s_ip_src;
   logic [1:0] s_ip;
   logic [1:0] s_conflicts;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   ip_update_arbiter #(.DEPTH(4), .CNT_WIDTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .a_valid  (a_valid),
      .a_in     (a_in),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_in     (b_in),
      .b_ready  (b_ready),
      .stall    (stall),
      .flush    (flush),
      .ip       (ip),
      .ip_valid (ip_valid),
      .ip_src   (ip_src),
      .conflicts(conflicts)
   );

   ip_update_arbiter #(.DEPTH(4), .CNT_WIDTH(2)) dut_sat (
      .clock    (clock),
      .reset    (reset),
      .a_valid  (s_a_valid),
      .a_in     (s_a_in),
      .a_ready  (s_a_ready),
      .b_valid  (s_b_valid),
      .b_in     (s_b_in),
      .b_ready  (s_b_ready),
      .stall    (s_stall),
      .flush    (s_flush),
      .ip       (s_ip),
      .ip_valid (s_ip_valid),
      .ip_src   (s_ip_src),
      .conflicts(s_conflicts)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (ip !== 2'd0) begin failures++; $display("FAIL rst_ip: got %0d expected 0", ip); end
      checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", ip_valid); end
      checks++; if (ip_src !== 1'b0) begin failures++; $display("FAIL rst_src: got %0b expected 0", ip_src); end
      checks++; if (conflicts !== 8'd0) begin failures++; $display("FAIL rst_conf: got %0d expected 0", conflicts); end
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
         failures++; $display("FAIL rst_ready: got a=%0b b=%0b expected 1 1", a_ready, b_ready);
      end
      tick();
      reset = 1'b1;
      tick();
      // Queue two A requests, let one through, then reset with one still pending.
      stall = 1'b1; a_valid = 1'b1; a_in = 2'd0;
      tick();
      a_in = 2'd1;
      tick();
      a_valid = 1'b0; stall = 1'b0;
      tick();
      checks++; if (ip !== 2'd1 || ip_valid !== 1'b1) begin
         failures++; $display("FAIL pre_rst_ip: got ip=%0d v=%0b expected ip=1 v=1", ip, ip_valid);
      end
      reset = 1'b0;
      #1;
      checks++; if (ip !== 2'd0 || ip_valid !== 1'b0) begin
         failures++; $display("FAIL async_rst_ip: got ip=%0d v=%0b expected ip=0 v=0", ip, ip_valid);
      end
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1 || conflicts !== 8'd0) begin
         failures++;
         $display("FAIL async_rst_state: got a=%0b b=%0b c=%0d expected 1 1 0", a_ready, b_ready,
                  conflicts);
      end
      #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ip_valid !== 1'b0) begin
            failures++; $display("FAIL post_rst_quiet: got v=%0b expected 0 (cycle %0d)", ip_valid, i);
         end
      end
   endtask

   task automatic test_single();
      a_valid = 1'b1; a_in = 2'd2;
      tick();
      a_valid = 1'b0;
      checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL single_bypass: got v=%0b expected 0", ip_valid); end
      tick();
      checks++; if (ip !== 2'd3 || ip_valid !== 1'b1 || ip_src !== 1'b0) begin
         failures++; $display("FAIL single_grant: got ip=%0d v=%0b s=%0b expected 3 1 0", ip, ip_valid, ip_src);
      end
      tick();
      checks++; if (ip !== 2'd3 || ip_valid !== 1'b0) begin
         failures++; $display("FAIL single_hold: got ip=%0d v=%0b expected 3 0", ip, ip_valid);
      end
   endtask

   task automatic test_conflict();
      a_valid = 1'b1; b_valid = 1'b1; a_in = 2'd0; b_in = 2'd0;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      checks++; if (ip !== 2'd1 || ip_src !== 1'b0 || ip_valid !== 1'b1) begin
         failures++; $display("FAIL conf1_first: got ip=%0d s=%0b v=%0b expected 1 0 1", ip, ip_src, ip_valid);
      end
      tick();
      checks++; if (ip !== 2'd3 || ip_src !== 1'b1 || ip_valid !== 1'b1) begin
         failures++; $display("FAIL conf1_second: got ip=%0d s=%0b v=%0b expected 3 1 1", ip, ip_src, ip_valid);
      end
      checks++; if (conflicts !== 8'd1) begin failures++; $display("FAIL conf1_count: got %0d expected 1", conflicts); end
      a_valid = 1'b1; b_valid = 1'b1; a_in = 2'd1; b_in = 2'd1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      checks++; if (ip !== 2'd2 || ip_src !== 1'b1 || ip_valid !== 1'b1) begin
         failures++; $display("FAIL conf2_first: got ip=%0d s=%0b v=%0b expected 2 1 1", ip, ip_src, ip_valid);
      end
      checks++; if (conflicts !== 8'd2) begin failures++; $display("FAIL conf2_count: got %0d expected 2", conflicts); end
      tick();
      checks++; if (ip !== 2'd2 || ip_src !== 1'b0 || ip_valid !== 1'b1) begin
         failures++; $display("FAIL conf2_second: got ip=%0d s=%0b v=%0b expected 2 0 1", ip, ip_src, ip_valid);
      end
      tick();
      checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL conf_idle: got v=%0b expected 0", ip_valid); end
   endtask

   task automatic test_flush();
      stall = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_in = 2'(i);
         tick();
         checks++; if (ip_valid !== 1'b0) begin
            failures++; $display("FAIL flush_stall_quiet: got v=%0b expected 0 (push %0d)", ip_valid, i);
         end
      end
      flush = 1'b1; b_in = 2'd3;
      tick();
      flush = 1'b0; b_valid = 1'b0; stall = 1'b0;
      checks++; if (b_ready !== 1'b1 || ip_valid !== 1'b0) begin
         failures++; $display("FAIL flush_edge: got rdy=%0b v=%0b expected 1 0", b_ready, ip_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ip_valid !== 1'b0 || ip !== 2'd2 || ip_src !== 1'b0) begin
            failures++;
            $display("FAIL flush_after: got v=%0b ip=%0d s=%0b expected 0 2 0", ip_valid, ip, ip_src);
         end
      end
      checks++; if (conflicts !== 8'd2) begin failures++; $display("FAIL flush_conf: got %0d expected 2", conflicts); end
   endtask

   task automatic test_backpressure();
      logic [1:0] exp_ip [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      stall = 1'b1; a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in = 2'(i);
         checks++; if (a_ready !== 1'b1) begin
            failures++; $display("FAIL bp_ready_fill: got %0b expected 1 (push %0d)", a_ready, i);
         end
         tick();
      end
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got %0b expected 0", a_ready); end
      a_in = 2'd0;
      tick();
      a_valid = 1'b0; stall = 1'b0;
      checks++; if (a_ready !== 1'b0 || ip_valid !== 1'b0) begin
         failures++; $display("FAIL bp_fifth: got rdy=%0b v=%0b expected 0 0", a_ready, ip_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (ip !== exp_ip[i] || ip_valid !== 1'b1 || ip_src !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got ip=%0d v=%0b s=%0b expected ip=%0d v=1 s=0 (pop %0d)", ip,
                     ip_valid, ip_src, exp_ip[i], i);
         end
      end
      tick();
      checks++; if (ip_valid !== 1'b0 || a_ready !== 1'b1) begin
         failures++; $display("FAIL bp_empty: got v=%0b rdy=%0b expected 0 1", ip_valid, a_ready);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int k = 0; k < 5; k++) begin
         s_a_valid = 1'b1; s_b_valid = 1'b1; s_a_in = 2'(k); s_b_in = 2'(k);
         tick();
         s_a_valid = 1'b0; s_b_valid = 1'b0;
         tick();
         checks++; if (s_conflicts !== exp_cnt[k] || s_ip_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_count: got c=%0d v=%0b expected c=%0d v=1 (round %0d)", s_conflicts,
                     s_ip_valid, exp_cnt[k], k);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0;
      a_valid = 1'b0; a_in = 2'd0; b_valid = 1'b0; b_in = 2'd0; stall = 1'b0; flush = 1'b0;
      s_a_valid = 1'b0; s_a_in = 2'd0; s_b_valid = 1'b0; s_b_in = 2'd0;
      s_stall = 1'b0; s_flush = 1'b0;
      test_reset();
      test_single();
      test_conflict();
      test_flush();
      test_backpressure();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
